// File: rtl/vid_frame_arbiter.sv
// vid_frame_arbiter: frame-granular round-robin arbiter that lets two Avalon-ST video sources share one deinterlacer.
// Defining VID_ARB_STATS_EN adds the frames0/frames1/orphans counters.
module vid_frame_arbiter #(
  parameter int SYMBOLS_PER_BEAT = 1,
  parameter int BITS_PER_SYMBOL  = 8,
  localparam int DW = SYMBOLS_PER_BEAT * BITS_PER_SYMBOL
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [DW-1:0] din0_data,
  input  logic          din0_valid,
  output logic          din0_ready,
  input  logic          din0_startofpacket,
  input  logic          din0_endofpacket,
  input  logic [DW-1:0] din1_data,
  input  logic          din1_valid,
  output logic          din1_ready,
  input  logic          din1_startofpacket,
  input  logic          din1_endofpacket,
  output logic [DW-1:0] dout_data,
  output logic          dout_valid,
  input  logic          dout_ready,
  output logic          dout_startofpacket,
  output logic          dout_endofpacket,
  output logic [1:0]    grant,
  output logic          state_dbg
`ifdef VID_ARB_STATS_EN
  ,
  output logic [15:0]   frames0,
  output logic [15:0]   frames1,
  output logic [15:0]   orphans
`endif
);

  // Handshake: a beat moves on a rising clock edge exactly when valid && ready are both high;
  // a source keeps data/sop/eop stable while valid && !ready, and ready never depends on a
  // later-cycle event.

  typedef enum logic {
    S_IDLE = 1'b0,
    S_PASS = 1'b1
  } state_t;

  state_t state_q, state_d;

  logic          rr_last_q;
  logic          owner_q;
  logic          frame_done_q;
  logic [1:0]    grant_q;
  logic [3:0]    type_q;

  logic          skid_valid_q;
  logic [DW-1:0] skid_data_q;
  logic          skid_sop_q;
  logic          skid_eop_q;

  logic          out_valid_q;
  logic [DW-1:0] out_data_q;
  logic          out_sop_q;
  logic          out_eop_q;

  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_sop;
  logic          in_eop;

  logic [1:0]    cand;
  logic          any_cand;
  logic          pick;
  logic          out_free;
  logic          pass_ready;
  logic          accept;
  logic [3:0]    eff_type;
  logic          video_eop;
  logic          drain_done;

  always_comb begin
    in_data  = owner_q ? din1_data          : din0_data;
    in_valid = owner_q ? din1_valid         : din0_valid;
    in_sop   = owner_q ? din1_startofpacket : din0_startofpacket;
    in_eop   = owner_q ? din1_endofpacket   : din0_endofpacket;
  end

  // On a tie the port that did not own the previous frame wins.
  assign cand     = {din1_valid & din1_startofpacket, din0_valid & din0_startofpacket};
  assign any_cand = |cand;
  assign pick     = (cand == 2'b11) ? ~rr_last_q : cand[1];

  assign out_free   = !out_valid_q || dout_ready;
  assign pass_ready = (state_q == S_PASS) && !skid_valid_q && !frame_done_q;
  assign accept     = pass_ready && in_valid;
  assign eff_type   = in_sop ? in_data[3:0] : type_q;
  assign video_eop  = accept && in_eop && (eff_type == 4'h0);
  assign drain_done = frame_done_q && !skid_valid_q && out_free;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (any_cand) state_d = S_PASS;
      S_PASS: if (drain_done) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Idle ports swallow beats that do not open a packet; only the owner is ever ready in PASS.
  always_comb begin
    din0_ready = 1'b0;
    din1_ready = 1'b0;
    case (state_q)
      S_IDLE: begin
        din0_ready = din0_valid & ~din0_startofpacket;
        din1_ready = din1_valid & ~din1_startofpacket;
      end
      S_PASS: begin
        if (owner_q) din1_ready = pass_ready;
        else         din0_ready = pass_ready;
      end
      default: begin
        din0_ready = 1'b0;
        din1_ready = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rr_last_q    <= 1'b1;
      owner_q      <= 1'b0;
      frame_done_q <= 1'b0;
      grant_q      <= 2'b00;
      type_q       <= 4'h0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      skid_sop_q   <= 1'b0;
      skid_eop_q   <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_sop_q    <= 1'b0;
      out_eop_q    <= 1'b0;
    end else begin
      if (state_q == S_IDLE && any_cand) begin
        grant_q      <= pick ? 2'b10 : 2'b01;
        owner_q      <= pick;
        frame_done_q <= 1'b0;
      end
      if (video_eop) begin
        grant_q      <= 2'b00;
        rr_last_q    <= owner_q;
        frame_done_q <= 1'b1;
      end
      if (accept && in_sop) type_q <= in_data[3:0];

      // The skid always drains ahead of new input, which keeps beat order intact.
      if (out_free) begin
        if (skid_valid_q) begin
          out_valid_q  <= 1'b1;
          out_data_q   <= skid_data_q;
          out_sop_q    <= skid_sop_q;
          out_eop_q    <= skid_eop_q;
          skid_valid_q <= 1'b0;
        end else if (accept) begin
          out_valid_q <= 1'b1;
          out_data_q  <= in_data;
          out_sop_q   <= in_sop;
          out_eop_q   <= in_eop;
        end else begin
          out_valid_q <= 1'b0;
        end
      end else if (accept) begin
        skid_valid_q <= 1'b1;
        skid_data_q  <= in_data;
        skid_sop_q   <= in_sop;
        skid_eop_q   <= in_eop;
      end
    end
  end

  assign dout_valid         = out_valid_q;
  assign dout_data          = out_data_q;
  assign dout_startofpacket = out_sop_q;
  assign dout_endofpacket   = out_eop_q;
  assign grant              = grant_q;
  assign state_dbg          = (state_q == S_PASS);

`ifdef VID_ARB_STATS_EN
  logic [1:0]  orphan_inc;
  logic [16:0] orphan_sum;

  assign orphan_inc = {1'b0, (state_q == S_IDLE) & din0_valid & din0_ready}
                    + {1'b0, (state_q == S_IDLE) & din1_valid & din1_ready};
  assign orphan_sum = {1'b0, orphans} + {15'd0, orphan_inc};

  always_ff @(posedge clock) begin
    if (reset) begin
      frames0 <= 16'd0;
      frames1 <= 16'd0;
      orphans <= 16'd0;
    end else begin
      if (video_eop && !owner_q && frames0 != 16'hFFFF) frames0 <= frames0 + 16'd1;
      if (video_eop &&  owner_q && frames1 != 16'hFFFF) frames1 <= frames1 + 16'd1;
      orphans <= orphan_sum[16] ? 16'hFFFF : orphan_sum[15:0];
    end
  end
`endif

endmodule
